// File: rtl/seq_add_pkg.sv
// Shared types and constants for the byte-serial add sequencer.
// Provides the FSM state encoding, the slice width and the idx width helper.
package seq_add_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Byte index width; a single-slice build still needs one bit.
    function automatic int idx_w(input int nbyte);
        return (nbyte <= 1) ? 1 : $clog2(nbyte);
    endfunction

endpackage

// File: rtl/rca8_slice.sv
// 8-bit ripple-carry adder slice, purely combinational.
// Ports: a, b, ci in; s (8-bit sum) and co (carry out of bit 7) out.
module rca8_slice
    import seq_add_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[SLICE_W];

endmodule

// File: rtl/seq_add_ctrl.sv
// Byte-serial wide adder: one rca8_slice reused over NBYTE cycles, with
// valid/ready operand input and result output. Optional macro SEQ_ADD_SUB_EN
// adds port op (1 = subtract). Ports: clk, rst (sync, active high),
// in_valid/in_ready, a, b, ci, [op], out_valid/out_ready, s, co, busy.
module seq_add_ctrl
    import seq_add_pkg::*;
#(
    parameter  int NBYTE = 4,
    localparam int W     = SLICE_W * NBYTE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
`ifdef SEQ_ADD_SUB_EN
    input  logic         op,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         co,
    output logic         busy
);

    localparam int IW = idx_w(NBYTE);
    localparam logic [IW-1:0] LAST = IW'(NBYTE - 1);

    typedef logic [NBYTE-1:0][SLICE_W-1:0] word_t;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    word_t         a_q, a_d;
    word_t         b_q, b_d;
    word_t         s_q, s_d;
    logic          carry_q, carry_d;
    logic          co_q, co_d;
`ifdef SEQ_ADD_SUB_EN
    logic          op_q, op_d;
`endif

    logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
    logic               sl_co;

    assign sl_a = a_q[idx_q];
`ifdef SEQ_ADD_SUB_EN
    // Subtract as a + ~b + 1; the +1 comes from carry_q seeded at accept.
    assign sl_b = op_q ? ~b_q[idx_q] : b_q[idx_q];
`else
    assign sl_b = b_q[idx_q];
`endif

    rca8_slice u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .ci (carry_q),
        .s  (sl_s),
        .co (sl_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        co_d    = co_q;
`ifdef SEQ_ADD_SUB_EN
        op_d    = op_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    s_d     = '0;
                    co_d    = 1'b0;
                    idx_d   = '0;
`ifdef SEQ_ADD_SUB_EN
                    op_d    = op;
                    carry_d = op ? 1'b1 : ci;
`else
                    carry_d = ci;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[idx_q] = sl_s;
                carry_d    = sl_co;
                if (idx_q == LAST) begin
                    co_d    = sl_co;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
`ifdef SEQ_ADD_SUB_EN
            op_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            co_q    <= co_d;
`ifdef SEQ_ADD_SUB_EN
            op_q    <= op_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign s         = s_q;
    assign co        = co_q;

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Directed and random checks for seq_add_ctrl with NBYTE = 4.
// Subtract vectors run only when SEQ_ADD_SUB_EN is defined.
module tb_seq_add_ctrl;

    localparam int NBYTE = 4;
    localparam int W     = 8 * NBYTE;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         op = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] s;
    logic         co;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_add_ctrl #(.NBYTE(NBYTE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef SEQ_ADD_SUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .busy      (busy)
    );

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tci, input logic top);
        @(negedge clk);
        a = ta; b = tb; ci = tci; op = top;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL wait_done timeout got out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic finish_op(input string nm);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s handshake got ov=%b ir=%b required ov=0 ir=1",
                     nm, out_valid, in_ready);
        end
    endtask

    task automatic run_vec(input string nm, input logic [W-1:0] ta,
                           input logic [W-1:0] tb, input logic tci,
                           input logic top, input logic [W:0] exp);
        int lat;
        start_op(ta, tb, tci, top);
        wait_done(lat);
        checks++;
        if ({co, s} !== exp) begin
            failures++;
            $display("FAIL %s got co=%b s=%h required co=%b s=%h",
                     nm, co, s, exp[W], exp[W-1:0]);
        end
        finish_op(nm);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            s !== '0 || co !== 1'b0) begin
            failures++;
            $display("FAIL reset got ov=%b ir=%b busy=%b s=%h co=%b required 0 1 0 0 0",
                     out_valid, in_ready, busy, s, co);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy got busy=%b ir=%b required 1 0", busy, in_ready);
        end
        wait_done(lat);
        checks++;
        if (lat !== NBYTE) begin
            failures++;
            $display("FAIL basic_latency got %0d required %0d", lat, NBYTE);
        end
        checks++;
        if ({co, s} !== 33'h0_0000_0100) begin
            failures++;
            $display("FAIL basic_sum got co=%b s=%h required co=0 s=00000100", co, s);
        end
        finish_op("basic");
    endtask

    task automatic test_full_ripple();
        run_vec("full_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                33'h1_0000_0000);
    endtask

    task automatic test_carry_in();
        run_vec("carry_in", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
                33'h0_2345_678A);
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   exp;
        for (int i = 0; i < 200; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rc  = 1'($urandom_range(0, 1));
            exp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_vec("random", ra, rb, rc, 1'b0, exp);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a = 32'hDEAD_BEEF;
            b = 32'h0BAD_F00D;
            @(posedge clk);
            #1;
            checks++;
            if ({co, s} !== 33'h0_1122_3344 || in_ready !== 1'b0 ||
                out_valid !== 1'b1) begin
                failures++;
                $display("FAIL backpressure got co=%b s=%h ir=%b ov=%b required 0 11223344 0 1",
                         co, s, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        finish_op("backpressure");
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_idle got busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        start_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (s[7:0] !== 8'h33) begin
            failures++;
            $display("FAIL midrun_slice0 got %h required 33", s[7:0]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== '0 || co !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset got ov=%b ir=%b s=%h co=%b required 0 1 0 0",
                     out_valid, in_ready, s, co);
        end
        run_vec("after_reset", 32'd3, 32'd4, 1'b0, 1'b0, 33'd7);
    endtask

`ifdef SEQ_ADD_SUB_EN
    task automatic test_sub();
        run_vec("sub_neg", 32'd5, 32'd7, 1'b1, 1'b1, 33'h0_FFFF_FFFE);
        run_vec("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 33'h1_0000_0002);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full_ripple();
        test_carry_in();
        test_random();
        test_backpressure();
        test_reset_mid_run();
`ifdef SEQ_ADD_SUB_EN
        test_sub();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
